stream_buffer: RTL
==================

Name: stream_buffer

Overview:
- Sequential-line instruction prefetcher beside i_cache; owns a private AXI read channel to memory.
- On an i_cache miss that also misses here, i_cache pulses alloc. The buffer flushes and prefetches the next DEPTH sequential lines into a FIFO.
- i_cache checks the FIFO head for each miss and, on hit, takes the whole line in one cycle instead of refilling from memory.

Parameters:
- ADDR_WIDTH, 26, byte address width (`ADDR_WIDTH).
- DATA_WIDTH, 32, word width (`DATA_WIDTH).
- BLOCK_OFFSET_WIDTH, 2, log2 words per line; LINE_SIZE = 1<<BLOCK_OFFSET_WIDTH; must match i_cache.
- DEPTH, 4, number of line entries; power of two, minimum 2.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- lookup_valid, in, 1, i_cache presents a miss line address.
- lookup_line_addr, in, LAW = ADDR_WIDTH-BLOCK_OFFSET_WIDTH-2, line address {tag,index}.
- lookup_hit, out, 1, combinational hit on the head entry.
- line_data, out, LINE_SIZE*DATA_WIDTH, head line; word 0 in the LSBs.
- consume, in, 1, pop head; honoured only when lookup_hit is 1.
- alloc, in, 1, flush and restart the stream.
- alloc_line_addr, in, LAW, missing line; prefetch starts at +1.
- mem_araddr, out, ADDR_WIDTH, {line_addr, zeros}.
- mem_arlen, out, 4, constant LINE_SIZE.
- mem_arid, out, 4, constant 4'd1.
- mem_arvalid, out, 1, read address valid.
- mem_arready, in, 1, read address ready.
- mem_rdata, in, DATA_WIDTH, read data beat.
- mem_rvalid, in, 1, read data valid.
- mem_rready, out, 1, constant 1.
- occupancy, out, log2(DEPTH)+1, number of complete valid entries.

Behaviour:
- Reset: state IDLE; all entries invalid; pointers 0; occupancy 0; mem_arvalid 0; lookup_hit 0. Reset mid-burst abandons the burst; memory is reset in the same cycle.
- Storage: circular FIFO of DEPTH entries {line_addr, words[LINE_SIZE], valid}. head_ptr/tail_ptr carry an extra wrap bit; full = DEPTH entries allocated, complete or filling.
- Hit: lookup_hit = lookup_valid & head.valid & (head.line_addr == lookup_line_addr). Zero latency. line_data always reflects the head.
- consume & lookup_hit: at the next edge, head is invalidated, head_ptr advances and occupancy decrements. consume without hit is ignored.
- Fill FSM states:
  - IDLE: while stream active and not full -> REQ.
  - REQ: mem_arvalid=1, mem_araddr={fetch_addr, zeros}. On arready: reserve the tail slot, tail_ptr++, fetch_addr++ (mod 2^LAW, wraps to 0) -> DATA.
  - DATA: each rvalid writes the beat to words[beat_cnt], beat_cnt++. On the last beat (beat_cnt==LINE_SIZE-1): entry valid, occupancy++, -> REQ if not full, else IDLE.
  - DRAIN: entered from DATA on alloc. Accept and discard remaining beats; on the last beat -> REQ. No new AR is issued until the drain completes.
- Prefetch issues only when a free slot exists; one burst outstanding at a time.
- alloc, any state: all entries invalid, pointers reset, occupancy 0, fetch_addr = alloc_line_addr+1, stream active.
  - From IDLE: -> REQ.
  - From REQ: -> REQ. mem_arvalid stays high and mem_araddr changes the next cycle; an AR accepted in the alloc cycle is treated as a DATA burst to drain (-> DRAIN).
  - From DATA: -> DRAIN.
- alloc and consume in the same cycle: alloc wins; consume is ignored.
- Consume in the same cycle as a last beat: both apply; occupancy is unchanged net.
- Last beat into the final free slot: full asserts and the FSM goes to IDLE until a consume frees a slot.
- Wrap: line-address increment wraps silently; pointers wrap mod DEPTH.

Optional Feature:
- Macro: STREAM_BUFFER_ALL_COMPARE_EN.
- Defined: lookup compares every valid entry; the lowest-age match hits and line_data muxes that entry. consume pops the matched entry and all older entries; occupancy drops by the count popped.
- Undefined: head-only compare as above; no extra comparators.

Decomposition:
- Package stream_buffer_pkg:
  - LAW localparam function.
  - sb_state_t enum {IDLE, REQ, DATA, DRAIN}.
  - sb_entry_t struct {line_addr, valid}.
- Sub-module sb_fill_ctrl: fill FSM, fetch_addr, beat_cnt and AXI read signals. It drives write-enable/index/word-select into the FIFO storage kept in stream_buffer.

Test Plan:
- Single alloc, no stall:
  - Stimulus: alloc, alloc_line_addr=0x100; arready and rvalid always 1; wait.
  - Response: four ARs at araddr 0x1010, 0x1020, 0x1030, 0x1040; occupancy reaches 4; no fifth AR.
- Hit and refill:
  - Stimulus: after the fill above, lookup 0x101 with consume.
  - Response: lookup_hit=1 the same cycle; line_data = beats of the first burst; occupancy 3; a new AR at 0x1050 within 2 cycles.
- Non-head lookup (feature off):
  - Stimulus: lookup 0x102 while the head is 0x101.
  - Response: lookup_hit=0; occupancy unchanged.
- Alloc mid-burst:
  - Stimulus: alloc 0x200 after 2 of 4 beats have arrived.
  - Response: 2 remaining beats discarded; next AR araddr=0x2010; no entry for 0x101 is ever valid.
- Wrap:
  - Stimulus: alloc 0xFFFF (LAW=22 max is 0x3FFFFF; use alloc_line_addr=0x3FFFFE).
  - Response: ARs for lines 0x3FFFFF, 0x000000, 0x000001, 0x000002.
- Reset mid-REQ:
  - Stimulus: assert rst while mem_arvalid=1.
  - Response: next cycle mem_arvalid=0, occupancy=0, lookup_hit=0.

Source files
------------

// File: rtl/stream_buffer_pkg.sv
// stream_buffer_pkg: shared types for the sequential-line prefetcher.
// Line-address width helper, fill FSM states and the FIFO entry tag.
package stream_buffer_pkg;

  function automatic int sb_law(input int aw, input int bow);
    return aw - bow - 2;
  endfunction

  localparam int SB_AW_DEF  = 26;
  localparam int SB_BOW_DEF = 2;
  localparam int SB_LAW     = sb_law(SB_AW_DEF, SB_BOW_DEF);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DRAIN
  } sb_state_t;

  typedef struct packed {
    logic [SB_LAW-1:0] line_addr;
    logic              valid;
  } sb_entry_t;

endpackage

// File: rtl/sb_fill_ctrl.sv
// sb_fill_ctrl: fill FSM for stream_buffer; owns fetch_addr, beat count
// and the AXI read address channel; drives FIFO write strobes.
// Ports: clk/rst; i_alloc, i_alloc_line_addr restart the stream;
// i_full from the FIFO; i_arready/i_rvalid from memory; o_arvalid,
// o_araddr to memory; o_fetch_addr, o_reserve, o_beat_we, o_beat_idx,
// o_line_done to the FIFO storage.
module sb_fill_ctrl
  import stream_buffer_pkg::*;
#(
  parameter  int ADDR_WIDTH         = 26,
  parameter  int BLOCK_OFFSET_WIDTH = 2,
  localparam int LAW = sb_law(ADDR_WIDTH, BLOCK_OFFSET_WIDTH),
  localparam int BOW = BLOCK_OFFSET_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_alloc,
  input  logic [LAW-1:0]        i_alloc_line_addr,
  input  logic                  i_full,
  input  logic                  i_arready,
  input  logic                  i_rvalid,
  output logic                  o_arvalid,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [LAW-1:0]        o_fetch_addr,
  output logic                  o_reserve,
  output logic                  o_beat_we,
  output logic [BOW-1:0]        o_beat_idx,
  output logic                  o_line_done
);

  sb_state_t      r_state;
  sb_state_t      w_next;
  logic [LAW-1:0] r_fetch_addr;
  logic [BOW-1:0] r_beat_cnt;
  logic           r_active;
  logic           w_ar_hs;
  logic           w_last;

  assign w_ar_hs = (r_state == REQ) && i_arready;
  assign w_last  = (r_beat_cnt == {BOW{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_alloc || (r_active && !i_full))
          w_next = REQ;
      end
      // An AR accepted in the alloc cycle belongs to the old stream.
      REQ: begin
        if (w_ar_hs)
          w_next = i_alloc ? DRAIN : DATA;
      end
      DATA: begin
        if (i_alloc)
          w_next = (i_rvalid && w_last) ? REQ : DRAIN;
        else if (i_rvalid && w_last)
          w_next = i_full ? IDLE : REQ;
      end
      DRAIN: begin
        if (i_rvalid && w_last)
          w_next = REQ;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_arvalid   = (r_state == REQ);
    o_reserve   = w_ar_hs && !i_alloc;
    o_beat_we   = (r_state == DATA) && i_rvalid && !i_alloc;
    o_line_done = o_beat_we && w_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_addr <= '0;
      r_beat_cnt   <= '0;
      r_active     <= 1'b0;
    end else begin
      if (i_alloc) begin
        r_fetch_addr <= i_alloc_line_addr + LAW'(1);
        r_active     <= 1'b1;
      end else if (w_ar_hs) begin
        r_fetch_addr <= r_fetch_addr + LAW'(1);
      end
      if ((r_state == DATA || r_state == DRAIN) && i_rvalid)
        r_beat_cnt <= r_beat_cnt + BOW'(1);
    end
  end

  assign o_araddr     = {r_fetch_addr, {(BOW + 2){1'b0}}};
  assign o_fetch_addr = r_fetch_addr;
  assign o_beat_idx   = r_beat_cnt;

endmodule

// File: rtl/stream_buffer.sv
// stream_buffer: sequential-line instruction prefetcher beside i_cache.
// Prefetches DEPTH lines after an alloc into a FIFO; head hits in 0 cycles.
// Ports: lookup_* / line_data / consume face i_cache; alloc* restarts;
// mem_ar* / mem_r* form a private AXI read channel; occupancy counts
// complete entries. Option STREAM_BUFFER_ALL_COMPARE_EN matches any entry.
module stream_buffer
  import stream_buffer_pkg::*;
#(
  parameter  int ADDR_WIDTH         = 26,
  parameter  int DATA_WIDTH         = 32,
  parameter  int BLOCK_OFFSET_WIDTH = 2,
  parameter  int DEPTH              = 4,
  localparam int LAW       = sb_law(ADDR_WIDTH, BLOCK_OFFSET_WIDTH),
  localparam int LINE_SIZE = 1 << BLOCK_OFFSET_WIDTH,
  localparam int LW        = LINE_SIZE * DATA_WIDTH,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int PTR_W     = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  input  logic [LAW-1:0]        lookup_line_addr,
  output logic                  lookup_hit,
  output logic [LW-1:0]         line_data,
  input  logic                  consume,
  input  logic                  alloc,
  input  logic [LAW-1:0]        alloc_line_addr,
  output logic [ADDR_WIDTH-1:0] mem_araddr,
  output logic [3:0]            mem_arlen,
  output logic [3:0]            mem_arid,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  output logic [PTR_W-1:0]      occupancy
);

  sb_entry_t       r_ent  [DEPTH];
  logic [LW-1:0]   r_line [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_occ;
  logic [IDX_W-1:0] r_fill_idx;

  logic [IDX_W-1:0] w_hidx;
  logic [IDX_W-1:0] w_tidx;
  logic [IDX_W-1:0] w_sel;
  logic [PTR_W-1:0] w_pop_n;
  logic             w_hit;
  logic             w_pop;
  logic             w_full;
  logic [LAW-1:0]   w_fetch_addr;
  logic             w_reserve;
  logic             w_beat_we;
  logic [BLOCK_OFFSET_WIDTH-1:0] w_beat_idx;
  logic             w_line_done;

  assign w_hidx = r_head[IDX_W-1:0];
  assign w_tidx = r_tail[IDX_W-1:0];
  // Filling entries count toward full so a reserved slot is never reused.
  assign w_full = (PTR_W'(r_tail - r_head) == PTR_W'(DEPTH));

`ifdef STREAM_BUFFER_ALL_COMPARE_EN
  // Scan oldest-last so the lowest-age match wins.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    w_hit   = 1'b0;
    w_sel   = w_hidx;
    w_pop_n = '0;
    v_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      v_idx = IDX_W'(w_hidx + IDX_W'(i));
      if (lookup_valid && r_ent[v_idx].valid &&
          r_ent[v_idx].line_addr == lookup_line_addr) begin
        w_hit   = 1'b1;
        w_sel   = v_idx;
        w_pop_n = PTR_W'(i + 1);
      end
    end
  end
`else
  always_comb begin
    w_sel   = w_hidx;
    w_pop_n = PTR_W'(1);
    w_hit   = lookup_valid && r_ent[w_hidx].valid &&
              (r_ent[w_hidx].line_addr == lookup_line_addr);
  end
`endif

  assign lookup_hit = w_hit;
  assign line_data  = r_line[w_sel];
  assign w_pop      = consume && w_hit && !alloc;

  sb_fill_ctrl #(
    .ADDR_WIDTH         (ADDR_WIDTH),
    .BLOCK_OFFSET_WIDTH (BLOCK_OFFSET_WIDTH)
  ) u_fill (
    .clk               (clk),
    .rst               (rst),
    .i_alloc           (alloc),
    .i_alloc_line_addr (alloc_line_addr),
    .i_full            (w_full),
    .i_arready         (mem_arready),
    .i_rvalid          (mem_rvalid),
    .o_arvalid         (mem_arvalid),
    .o_araddr          (mem_araddr),
    .o_fetch_addr      (w_fetch_addr),
    .o_reserve         (w_reserve),
    .o_beat_we         (w_beat_we),
    .o_beat_idx        (w_beat_idx),
    .o_line_done       (w_line_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= '0;
      r_fill_idx <= '0;
    end else if (alloc) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH; i++)
          if (PTR_W'(i) < w_pop_n)
            r_ent[IDX_W'(w_hidx + IDX_W'(i))].valid <= 1'b0;
        r_head <= r_head + w_pop_n;
      end
      if (w_reserve) begin
        r_ent[w_tidx].line_addr <= w_fetch_addr;
        r_ent[w_tidx].valid     <= 1'b0;
        r_fill_idx              <= w_tidx;
        r_tail                  <= r_tail + PTR_W'(1);
      end
      if (w_line_done)
        r_ent[r_fill_idx].valid <= 1'b1;
      r_occ <= r_occ + PTR_W'(w_line_done) - (w_pop ? w_pop_n : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_beat_we)
      r_line[r_fill_idx][int'(w_beat_idx) * DATA_WIDTH +: DATA_WIDTH]
        <= mem_rdata;
  end

  assign mem_arlen  = 4'(LINE_SIZE);
  assign mem_arid   = 4'd1;
  assign mem_rready = 1'b1;
  assign occupancy  = r_occ;

endmodule
